// File: rtl/current_tile_memory_if.sv
// Tile-type package and the executor <-> current-tile-memory handshake interface.
// The master (executor) drives the strobes and new fields; the slave holds the tile state.
package current_tile_memory_pkg;
  typedef enum logic [2:0] {eNon, eI, eO, eT, eS, eZ, eJ, eL} tile_type_e;
endpackage

interface current_tile_memory_if #(
  parameter int unsigned width_p  = 16,
  parameter int unsigned height_p = 32
);
  import current_tile_memory_pkg::*;

  localparam int unsigned XW = $clog2(width_p);
  localparam int unsigned YW = $clog2(height_p);

  logic            set_v;
  tile_type_e      set_type;
  logic [1:0]      set_angle;
  logic            pos_set_v;
  logic [XW-1:0]   set_x;
  logic [YW-1:0]   set_y;
  logic            cm_is_ready;
  tile_type_e      cur_type;
  logic [1:0]      cur_angle;
  logic [XW-1:0]   cur_x;
  logic [YW-1:0]   cur_y;
  logic            cell_v;
  logic [1:0]      cell_idx;
  logic [XW:0]     cell_x;
  logic [YW:0]     cell_y;
  logic            in_bounds;

  modport master (
    output set_v, set_type, set_angle, pos_set_v, set_x, set_y,
    input  cm_is_ready, cur_type, cur_angle, cur_x, cur_y,
    input  cell_v, cell_idx, cell_x, cell_y, in_bounds
  );

  modport slave (
    input  set_v, set_type, set_angle, pos_set_v, set_x, set_y,
    output cm_is_ready, cur_type, cur_angle, cur_x, cur_y,
    output cell_v, cell_idx, cell_x, cell_y, in_bounds
  );
endinterface

// File: rtl/current_tile_memory.sv
// Holds the active tile and, after each accepted set strobe, walks its four cells through a
// shape ROM, presenting absolute board coordinates and an in-bounds summary.
module current_tile_memory
  import current_tile_memory_pkg::*;
#(
  parameter int unsigned width_p  = 16,
  parameter int unsigned height_p = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  current_tile_memory_if.slave bus
);

  localparam int unsigned XW  = $clog2(width_p);
  localparam int unsigned YW  = $clog2(height_p);
  localparam int unsigned CXW = XW + 1;
  localparam int unsigned CYW = YW + 1;
  localparam logic [CXW-1:0] XLim = CXW'(width_p);
  localparam logic [CYW-1:0] YLim = CYW'(height_p);

  typedef enum logic [0:0] {eIDLE, eWALK} state_e;

  // Each entry packs four {dx,dy} nibbles, cell 0 in the top nibble.
  function automatic logic [15:0] shape_rom(tile_type_e t, logic [1:0] a);
    logic [15:0] s;
    s = 16'h0000;
    case (t)
      eI: s = a[0] ? 16'h89AB : 16'h159D;
      eO: s = 16'h4859;
      eT: case (a) 2'd0: s = 16'h4159; 2'd1: s = 16'h4596; 2'd2: s = 16'h1596; default: s = 16'h4156; endcase
      eS: case (a) 2'd0: s = 16'h4815; 2'd1: s = 16'h459A; 2'd2: s = 16'h5926; default: s = 16'h0156; endcase
      eZ: case (a) 2'd0: s = 16'h0459; 2'd1: s = 16'h8596; 2'd2: s = 16'h156A; default: s = 16'h4152; endcase
      eJ: case (a) 2'd0: s = 16'h0159; 2'd1: s = 16'h4856; 2'd2: s = 16'h159A; default: s = 16'h4526; endcase
      eL: case (a) 2'd0: s = 16'h8159; 2'd1: s = 16'h456A; 2'd2: s = 16'h1592; default: s = 16'h0456; endcase
      default: s = 16'h0000;
    endcase
    return s;
  endfunction

  state_e          state_q;
  tile_type_e      type_q;
  logic [1:0]      angle_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic            ready_q, cell_v_q, in_bounds_q;
  logic [1:0]      idx_q;
  logic [CXW-1:0]  cell_x_q;
  logic [CYW-1:0]  cell_y_q;

  logic            start;
  tile_type_e      nxt_type;
  logic [1:0]      nxt_angle, nxt_idx;
  logic [XW-1:0]   nxt_x;
  logic [YW-1:0]   nxt_y;
  logic [15:0]     shape;
  logic [3:0]      nib;
  logic [CXW-1:0]  nxt_cx;
  logic [CYW-1:0]  nxt_cy;
  logic            nxt_ok;

  // Next presented cell uses the incoming fields on the accepting edge.
  always_comb begin
    start     = (state_q == eIDLE) && (bus.set_v || bus.pos_set_v);
    nxt_type  = (start && bus.set_v) ? bus.set_type : type_q;
    nxt_angle = (start && bus.set_v) ? bus.set_angle : angle_q;
    nxt_x     = (start && bus.pos_set_v) ? bus.set_x : x_q;
    nxt_y     = (start && bus.pos_set_v) ? bus.set_y : y_q;
    nxt_idx   = start ? 2'd0 : idx_q + 2'd1;
    shape     = shape_rom(nxt_type, nxt_angle);
    case (nxt_idx)
      2'd0:    nib = shape[15:12];
      2'd1:    nib = shape[11:8];
      2'd2:    nib = shape[7:4];
      default: nib = shape[3:0];
    endcase
    nxt_cx = {1'b0, nxt_x} + CXW'(nib[3:2]);
    nxt_cy = {1'b0, nxt_y} + CYW'(nib[1:0]);
    nxt_ok = (nxt_type == eNon) || ((nxt_cx < XLim) && (nxt_cy < YLim));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= eIDLE;
      type_q      <= eNon;
      angle_q     <= 2'd0;
      x_q         <= '0;
      y_q         <= '0;
      ready_q     <= 1'b1;
      cell_v_q    <= 1'b0;
      idx_q       <= 2'd0;
      cell_x_q    <= '0;
      cell_y_q    <= '0;
      in_bounds_q <= 1'b1;
    end else begin
      case (state_q)
        eIDLE: begin
          if (start) begin
            state_q     <= eWALK;
            type_q      <= nxt_type;
            angle_q     <= nxt_angle;
            x_q         <= nxt_x;
            y_q         <= nxt_y;
            ready_q     <= 1'b0;
            idx_q       <= nxt_idx;
            cell_v_q    <= (nxt_type != eNon);
            cell_x_q    <= nxt_cx;
            cell_y_q    <= nxt_cy;
            in_bounds_q <= nxt_ok;
          end
        end
        default: begin
          if (idx_q == 2'd3) begin
            state_q  <= eIDLE;
            ready_q  <= 1'b1;
            cell_v_q <= 1'b0;
          end else begin
            idx_q       <= nxt_idx;
            cell_v_q    <= (type_q != eNon);
            cell_x_q    <= nxt_cx;
            cell_y_q    <= nxt_cy;
            in_bounds_q <= in_bounds_q && nxt_ok;
          end
        end
      endcase
    end
  end

  assign bus.cm_is_ready = ready_q;
  assign bus.cur_type    = type_q;
  assign bus.cur_angle   = angle_q;
  assign bus.cur_x       = x_q;
  assign bus.cur_y       = y_q;
  assign bus.cell_v      = cell_v_q;
  assign bus.cell_idx    = idx_q;
  assign bus.cell_x      = cell_x_q;
  assign bus.cell_y      = cell_y_q;
  assign bus.in_bounds   = in_bounds_q;

endmodule

// File: tb/tb_current_tile_memory.sv
// Bench for current_tile_memory: directed scenarios plus random walks checked against a
// coordinate-list model of the tile shapes.
module tb_current_tile_memory;
  import current_tile_memory_pkg::*;

  localparam int W = 16;
  localparam int H = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  // Expected tile state as tracked by the bench.
  int   m_type, m_angle, m_x, m_y;
  // Cell offsets as "dx dy" digit pairs, cells 0..3, indexed [type-1][angle].
  string shp [7][4];

  current_tile_memory_if #(.width_p(W), .height_p(H)) bus ();

  current_tile_memory #(.width_p(W), .height_p(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void init_shapes();
    shp[0] = '{"01112131", "20212223", "01112131", "20212223"};  // I
    shp[1] = '{"10201121", "10201121", "10201121", "10201121"};  // O
    shp[2] = '{"10011121", "10112112", "01112112", "10011112"};  // T
    shp[3] = '{"10200111", "10112122", "11210212", "00011112"};  // S
    shp[4] = '{"00101121", "20112112", "01111222", "10011102"};  // Z
    shp[5] = '{"00011121", "10201112", "01112122", "10110212"};  // J
    shp[6] = '{"20011121", "10111222", "01112102", "00101112"};  // L
  endfunction

  function automatic void idle_inputs();
    bus.set_v     = 1'b0;
    bus.pos_set_v = 1'b0;
  endfunction

  // Drives one strobe from an idle DUT and checks the whole walk cycle by cycle.
  task automatic run_walk(input bit sv, input bit pv, input int t, input int a,
                          input int x, input int y, input bit poke, input string name);
    int ex, ey;
    bit inb;
    if (sv) begin m_type = t; m_angle = a; end
    if (pv) begin m_x = x; m_y = y; end
    bus.set_v     = sv;
    bus.pos_set_v = pv;
    bus.set_type  = tile_type_e'(t);
    bus.set_angle = 2'(a);
    bus.set_x     = 4'(x);
    bus.set_y     = 5'(y);
    @(posedge clk); #1;
    idle_inputs();
    inb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (poke && k == 1) begin
        bus.set_v     = 1'b1;
        bus.pos_set_v = 1'b1;
        bus.set_type  = tile_type_e'((m_type % 7) + 1);
        bus.set_angle = 2'(m_angle + 1);
        bus.set_x     = 4'(m_x + 3);
        bus.set_y     = 5'(m_y + 5);
      end
      n_cmp++;
      if (bus.cm_is_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s ready_low[%0d]: got %b want 0", name, k, bus.cm_is_ready);
      end
      n_cmp++;
      if (bus.cell_v !== (m_type != 0)) begin
        n_err++;
        $display("FAIL %s cell_v[%0d]: got %b want %b", name, k, bus.cell_v, m_type != 0);
      end
      if (m_type != 0) begin
        ex = m_x + (shp[m_type-1][m_angle].getc(2*k) - "0");
        ey = m_y + (shp[m_type-1][m_angle].getc(2*k+1) - "0");
        inb = inb && (ex < W) && (ey < H);
        n_cmp++;
        if (bus.cell_idx !== 2'(k) || bus.cell_x !== 5'(ex) || bus.cell_y !== 6'(ey)) begin
          n_err++;
          $display("FAIL %s cell[%0d]: got idx%0d (%0d,%0d) want idx%0d (%0d,%0d)", name, k,
                   bus.cell_idx, bus.cell_x, bus.cell_y, k, ex, ey);
        end
      end
      @(posedge clk); #1;
      idle_inputs();
    end
    n_cmp++;
    if (bus.cm_is_ready !== 1'b1 || bus.cell_v !== 1'b0 || bus.in_bounds !== inb) begin
      n_err++;
      $display("FAIL %s end: got ready=%b v=%b inb=%b want ready=1 v=0 inb=%b", name,
               bus.cm_is_ready, bus.cell_v, bus.in_bounds, inb);
    end
    n_cmp++;
    if (bus.cur_type !== 3'(m_type) || bus.cur_angle !== 2'(m_angle) ||
        bus.cur_x !== 4'(m_x) || bus.cur_y !== 5'(m_y)) begin
      n_err++;
      $display("FAIL %s fields: got t%0d a%0d (%0d,%0d) want t%0d a%0d (%0d,%0d)", name,
               bus.cur_type, bus.cur_angle, bus.cur_x, bus.cur_y, m_type, m_angle, m_x, m_y);
    end
  endtask

  task automatic test_reset();
    // Start a walk, then pull reset one cycle in.
    bus.set_v = 1'b1; bus.pos_set_v = 1'b1;
    bus.set_type = eL; bus.set_angle = 2'd2; bus.set_x = 4'd5; bus.set_y = 5'd7;
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.cm_is_ready !== 1'b1 || bus.cur_type !== eNon || bus.cur_angle !== 2'd0 ||
        bus.cur_x !== 4'd0 || bus.cur_y !== 5'd0 || bus.cell_v !== 1'b0 ||
        bus.cell_idx !== 2'd0 || bus.cell_x !== 5'd0 || bus.cell_y !== 6'd0 ||
        bus.in_bounds !== 1'b1) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b t=%0d a=%0d x=%0d y=%0d v=%b i=%0d cx=%0d cy=%0d ib=%b want 1,0,0,0,0,0,0,0,0,1",
               bus.cm_is_ready, bus.cur_type, bus.cur_angle, bus.cur_x, bus.cur_y,
               bus.cell_v, bus.cell_idx, bus.cell_x, bus.cell_y, bus.in_bounds);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_type = 0; m_angle = 0; m_x = 0; m_y = 0;
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (bus.cell_v !== 1'b0 || bus.cm_is_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_abort[%0d]: got v=%b rdy=%b want v=0 rdy=1", c, bus.cell_v,
                 bus.cm_is_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_i_vertical();
    run_walk(1'b1, 1'b1, eI, 1, 4, 0, 1'b0, "i_vertical");
  endtask

  task automatic test_i_overflow();
    run_walk(1'b1, 1'b1, eI, 0, 13, 5, 1'b0, "i_overflow");
  endtask

  task automatic test_o_bottom();
    run_walk(1'b1, 1'b1, eO, 0, 0, 30, 1'b0, "o_bottom_in");
    run_walk(1'b0, 1'b1, eO, 0, 0, 31, 1'b0, "o_bottom_out");
  endtask

  task automatic test_ignore_midwalk();
    run_walk(1'b1, 1'b1, eT, 3, 6, 10, 1'b1, "ignore_midwalk");
  endtask

  task automatic test_executor_loop();
    int cycles;
    run_walk(1'b1, 1'b0, eJ, 0, 0, 0, 1'b0, "exec_start");
    for (int r = 0; r < 4; r++) begin
      m_angle = (m_angle + 1) % 4;
      bus.set_v = 1'b1; bus.set_type = eJ; bus.set_angle = 2'(m_angle);
      @(posedge clk); #1;
      idle_inputs();
      cycles = 1;
      while (bus.cm_is_ready !== 1'b1 && cycles < 12) begin
        @(posedge clk); #1;
        cycles++;
      end
      n_cmp++;
      if (cycles != 5 || bus.cur_angle !== 2'(m_angle)) begin
        n_err++;
        $display("FAIL exec_loop[%0d]: got %0d cycles angle %0d want 5 cycles angle %0d", r,
                 cycles, bus.cur_angle, m_angle);
      end
    end
  endtask

  task automatic test_random();
    bit sv, pv;
    for (int i = 0; i < 40; i++) begin
      sv = 1'($urandom_range(0, 1));
      pv = sv ? 1'($urandom_range(0, 1)) : 1'b1;
      run_walk(sv, pv, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
               1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    init_shapes();
    rst_n = 1'b0;
    bus.set_v = 1'b0; bus.pos_set_v = 1'b0; bus.set_type = eNon;
    bus.set_angle = 2'd0; bus.set_x = 4'd0; bus.set_y = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_i_vertical();
    test_i_overflow();
    test_o_bottom();
    test_ignore_midwalk();
    test_executor_loop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
